i2c_codec_cfg_slave: RTL and testbench
======================================

Name: i2c_codec_cfg_slave

Overview:
I2C target (responder) for the 3-byte codec configuration write [SLAVE_ADDR, SUB_ADDR, DATA]. This is the frame our configuration master issues, with slave byte 8'h34. The block decodes each 16-bit word as a 7-bit register address plus 9-bit data, acknowledges per I2C, and updates a 16-entry shadow register file. It stands in for the codec on-chip and in system benches, so the configuration sequence and volume writes can be checked and read back.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address (write byte 8'h34)
NUM_REGS, 16, shadow register count; valid register addresses 0..NUM_REGS-1
RESET_REG, 7'h0F, register address whose write clears the whole shadow file

Ports:
iCLK  input  1  system clock, 50 MHz nominal; all logic on posedge
iRST_N  input  1  asynchronous active-low reset
I2C_SCLK  input  1  I2C clock from master
I2C_SDAT  inout  1  I2C data; block only drives 0 or releases to Z (open-drain)
iRD_ADDR  input  4  shadow file read address
oRD_DATA  output  9  shadow file content at iRD_ADDR, combinational
oREG_WE  output  1  one-cycle pulse per accepted register write
oREG_ADDR  output  7  register address of last accepted write
oREG_DATA  output  9  data of last accepted write
oBUSY  output  1  high from address match until STOP or abort
oXFER_CNT  output  8  count of accepted writes, wraps 255->0

Behaviour:
- Reset (async, iRST_N low): I2C_SDAT released immediately, FSM=IDLE, all shadow registers 0, oREG_WE=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0, oXFER_CNT=0.
- Input conditioning: SCL and SDA each pass a 2-FF synchronizer plus one history FF. Edges are detected on the synchronized signals only.
- START: synced SDA falls while SCL high. STOP: synced SDA rises while SCL high. Data bits are sampled on the synced SCL rising edge, MSB first.
- START in any state, including mid-byte, goes to ADDR with the bit counter cleared (repeated START).
- STOP in any state goes to IDLE, releases SDA and clears oBUSY. A partially received word is discarded with no write.
- FSM: IDLE -> (START) ADDR -> ACK_A -> BYTE1 -> ACK_1 -> BYTE2 -> ACK_2 -> WAIT_STOP.
  - ADDR: 8 bits. Accept only when byte[7:1]==DEV_ADDR and byte[0]==0; oBUSY goes high. On mismatch or R/W=1, go to IDLE with no ACK; the block ignores everything until the next START.
  - ACK_x: SDA is driven low from the first synced SCL falling edge after bit 8 until the next synced SCL falling edge, then released.
  - BYTE1 holds reg_addr=byte[7:1] and data[8]=byte[0]. BYTE2 holds data[7:0].
- Write commit: in the iCLK cycle after the 8th BYTE2 bit is sampled:
  - oREG_WE=1 for exactly one cycle.
  - oREG_ADDR and oREG_DATA are updated.
  - oXFER_CNT increments.
  - If reg_addr==RESET_REG and data==0, all shadow registers clear to 0.
  - Else if reg_addr<NUM_REGS, shadow[reg_addr] is written.
  - Else no shadow update; the write is still ACKed and still pulses oREG_WE.
- WAIT_STOP: further bytes are not ACKed (SDA stays released). Wait for STOP or START.
- Read port: oRD_DATA reflects a write starting the cycle after the commit.
- SDA is never driven high. While SCL is high, SDA is never changed except through the ACK release on the SCL falling edge.

Test Plan:
- Reset, then frame 34/04/ED (SET_HEAD_L, 1'b1+VOL 7'h6D) and STOP -> three ACK low slots, one oREG_WE pulse, oREG_ADDR=7'h02, oREG_DATA=9'h0ED, oRD_DATA at iRD_ADDR=2 is 9'h0ED, oXFER_CNT=1.
- Full 11-word config sequence (00,0000 ... 1201) -> oXFER_CNT=11; shadow[4]=9'h012, shadow[7]=9'h002, shadow[8]=9'h022, shadow[9]=9'h001.
- Address byte 8'h36 or 8'h35 -> SDA never driven low, no oREG_WE, oBUSY stays 0; a following valid frame is accepted normally.
- STOP after BYTE1, and separately a repeated START mid-BYTE2 followed by a full frame 34/06/D6 -> first frame produces no write; second produces oREG_ADDR=7'h03, oREG_DATA=9'h0D6.
- Write 34/1E/00 after the config sequence -> all shadow registers read 0; oREG_WE pulses; oXFER_CNT increments. Fourth data byte in any frame -> NACK, no extra write.
- Assert iRST_N low during ACK_1 -> SDA released within the same cycle, all outputs return to reset values; the next frame is accepted.

Source files
------------

// File: rtl/i2c_codec_cfg_slave.sv
// I2C write-only target for 3-byte codec config frames.
// Decodes {reg_addr[6:0], data[8:0]} and keeps a shadow register file.
module i2c_codec_cfg_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 16,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic       oBUSY,
  output logic [7:0] oXFER_CNT
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1,
    S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_q, scl_d;
  logic [2:0]  sda_q, sda_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic        ack_ph_q, ack_ph_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [6:0]  hold_addr_q, hold_addr_d;
  logic        hold_d8_q, hold_d8_d;
  logic        we_q, we_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [8:0]  reg_data_q, reg_data_d;
  logic [7:0]  xfer_q, xfer_d;
  logic [8:0]  shadow_q [NUM_REGS];
  logic [8:0]  shadow_d [NUM_REGS];

  logic scl_s, sda_s, scl_rise, scl_fall;
  logic start_c, stop_c;
  logic [7:0] byte_in;

  // Bit 0 is the first sync stage, bit 1 the synced value, bit 2 history.
  assign scl_d    = {scl_q[1:0], I2C_SCLK};
  assign sda_d    = {sda_q[1:0], I2C_SDAT};
  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_q[2];
  assign scl_fall = ~scl_s & scl_q[2];
  assign start_c  = scl_s & sda_q[2] & ~sda_s;
  assign stop_c   = scl_s & ~sda_q[2] & sda_s;
  assign byte_in  = {sh_q, sda_s};

  assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
  assign oRD_DATA  = shadow_q[iRD_ADDR];
  assign oREG_WE   = we_q;
  assign oREG_ADDR = reg_addr_q;
  assign oREG_DATA = reg_data_q;
  assign oBUSY     = busy_q;
  assign oXFER_CNT = xfer_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ack_ph_d    = ack_ph_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    hold_addr_d = hold_addr_q;
    hold_d8_d   = hold_d8_q;
    we_d        = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    xfer_d      = xfer_q;
    if (stop_c) begin
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      ack_ph_d = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      ack_ph_d = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_ph_d = 1'b0;
              unique case (state_q)
                S_ADDR: begin
                  if (byte_in == {DEV_ADDR, 1'b0}) begin
                    state_d = S_ACK_A;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                  end
                end
                S_BYTE1: begin
                  hold_addr_d = byte_in[7:1];
                  hold_d8_d   = byte_in[0];
                  state_d     = S_ACK_1;
                end
                default: begin
                  we_d       = 1'b1;
                  reg_addr_d = hold_addr_q;
                  reg_data_d = {hold_d8_q, byte_in};
                  xfer_d     = xfer_q + 8'd1;
                  state_d    = S_ACK_2;
                end
              endcase
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          // First fall after bit 8 grabs SDA, the next one lets go.
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b0;
              cnt_d    = 3'd0;
              unique case (state_q)
                S_ACK_A: state_d = S_BYTE1;
                S_ACK_1: state_d = S_BYTE2;
                default: state_d = S_WAIT;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = shadow_q[i];
    if (we_q) begin
      if (reg_addr_q == RESET_REG && reg_data_q == 9'd0) begin
        for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = 9'd0;
      end else if (32'(reg_addr_q) < NUM_REGS) begin
        shadow_d[reg_addr_q[AW-1:0]] = reg_data_q;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      cnt_q       <= 3'd0;
      sh_q        <= 7'd0;
      ack_ph_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      hold_addr_q <= 7'd0;
      hold_d8_q   <= 1'b0;
      we_q        <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_data_q  <= 9'd0;
      xfer_q      <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= 9'd0;
    end else begin
      state_q     <= state_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ack_ph_q    <= ack_ph_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      hold_addr_q <= hold_addr_d;
      hold_d8_q   <= hold_d8_d;
      we_q        <= we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      xfer_q      <= xfer_d;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

endmodule

// File: tb/tb_i2c_codec_cfg_slave.sv
// Bench for i2c_codec_cfg_slave: bit-banged I2C master
// against a frame-level shadow-file model.
module tb_i2c_codec_cfg_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  wire        sda;
  wire  [8:0] rd_data;
  wire        reg_we;
  wire  [6:0] reg_addr;
  wire  [8:0] reg_data;
  wire        busy;
  wire  [7:0] xfer_cnt;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_codec_cfg_slave dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda),
    .iRD_ADDR (rd_addr),
    .oRD_DATA (rd_data),
    .oREG_WE  (reg_we),
    .oREG_ADDR(reg_addr),
    .oREG_DATA(reg_data),
    .oBUSY    (busy),
    .oXFER_CNT(xfer_cnt)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we_double = 0;
  int dut_low = 0;
  int busy_hits = 0;
  logic we_prev = 1'b0;

  always @(negedge clk) begin
    if (reg_we) we_cnt++;
    if (reg_we && we_prev) we_double++;
    we_prev = reg_we;
    if (!m_low && sda === 1'b0) dut_low++;
    if (busy) busy_hits++;
  end

  // Frame-level reference: shadow file, last write, write count.
  logic [8:0] mdl [16];
  int         m_cnt;
  logic [6:0] m_addr;
  logic [8:0] m_data;

  function automatic void mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 9'd0;
    m_cnt  = 0;
    m_addr = 7'd0;
    m_data = 9'd0;
  endfunction

  function automatic void mdl_write(logic [7:0] b1, logic [7:0] b2);
    logic [6:0] a;
    logic [8:0] d;
    a = b1[7:1];
    d = {b1[0], b2};
    if (a == 7'h0F && d == 9'd0) begin
      for (int i = 0; i < 16; i++) mdl[i] = 9'd0;
    end else if (a < 7'd16) begin
      mdl[a[3:0]] = d;
    end
    m_cnt  = (m_cnt + 1) % 256;
    m_addr = a;
    m_data = d;
  endfunction

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b, output logic s);
    wt(4);
    m_low = ~b;
    wt(3);
    scl = 1'b1;
    wt(5);
    s = sda;
    wt(5);
    scl = 1'b0;
  endtask

  task automatic start_c();
    m_low = 1'b0;
    wt(4);
    scl = 1'b1;
    wt(4);
    m_low = 1'b1;
    wt(4);
    scl = 1'b0;
  endtask

  task automatic stop_c();
    wt(4);
    m_low = 1'b1;
    wt(3);
    scl = 1'b1;
    wt(4);
    m_low = 1'b0;
    wt(6);
  endtask

  task automatic bits_out(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
  endtask

  task automatic byte_out(input logic [7:0] b, output logic ack);
    logic s;
    bits_out(b);
    bit_out(1'b1, s);
    ack = (s === 1'b0);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input int n, output logic [3:0] acks);
    logic [7:0] bb [4];
    logic a;
    bb = '{b0, b1, b2, b3};
    acks = 4'd0;
    start_c();
    for (int i = 0; i < n; i++) begin
      byte_out(bb[i], a);
      acks[i] = a;
    end
    stop_c();
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      wt(1);
      checks++;
      if (rd_data !== mdl[i]) begin
        errors++;
        $display("FAIL %s shadow[%0d] got %h want %h", tag, i, rd_data, mdl[i]);
      end
    end
  endtask

  task automatic check_last(input string tag);
    checks++;
    if (xfer_cnt !== 8'(m_cnt) || reg_addr !== m_addr || reg_data !== m_data) begin
      errors++;
      $display("FAIL %s last cnt/addr/data got %h/%h/%h want %h/%h/%h", tag,
               xfer_cnt, reg_addr, reg_data, 8'(m_cnt), m_addr, m_data);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wt(3);
    rst_n = 1'b1;
    wt(3);
    mdl_reset();
  endtask

  task automatic test_reset();
    mdl_reset();
    wt(3);
    checks++;
    if (sda !== 1'b1 || reg_we !== 1'b0 || busy !== 1'b0 ||
        reg_addr !== 7'd0 || reg_data !== 9'd0 || xfer_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset outputs sda=%b we=%b busy=%b a=%h d=%h c=%h want 1/0/0/0/0/0",
               sda, reg_we, busy, reg_addr, reg_data, xfer_cnt);
    end
    rst_n = 1'b1;
    wt(3);
    check_file("reset");
  endtask

  task automatic test_single();
    logic [3:0] acks;
    int w0;
    w0 = we_cnt;
    frame(8'h34, 8'h04, 8'hED, 8'h00, 3, acks);
    mdl_write(8'h04, 8'hED);
    checks++;
    if (acks[2:0] !== 3'b111) begin
      errors++;
      $display("FAIL single acks got %b want 111", acks[2:0]);
    end
    checks++;
    if (we_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL single we_pulses got %0d want 1", we_cnt - w0);
    end
    checks++;
    if (reg_addr !== 7'h02 || reg_data !== 9'h0ED || xfer_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single a/d/c got %h/%h/%h want 02/0ed/01", reg_addr, reg_data, xfer_cnt);
    end
    rd_addr = 4'd2;
    wt(1);
    checks++;
    if (rd_data !== 9'h0ED) begin
      errors++;
      $display("FAIL single rd2 got %h want 0ed", rd_data);
    end
    checks++;
    if (busy !== 1'b0 || sda !== 1'b1) begin
      errors++;
      $display("FAIL single idle busy/sda got %b/%b want 0/1", busy, sda);
    end
  endtask

  task automatic test_config();
    logic [15:0] cfg [11];
    logic [3:0] acks;
    logic [8:0] want [4];
    int idx [4];
    cfg = '{16'h0000, 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h0812,
            16'h0A06, 16'h0C00, 16'h0E02, 16'h1022, 16'h1201};
    want = '{9'h012, 9'h002, 9'h022, 9'h001};
    idx = '{4, 7, 8, 9};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      frame(8'h34, cfg[i][15:8], cfg[i][7:0], 8'h00, 3, acks);
      mdl_write(cfg[i][15:8], cfg[i][7:0]);
    end
    checks++;
    if (xfer_cnt !== 8'd11) begin
      errors++;
      $display("FAIL config count got %0d want 11", xfer_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      rd_addr = 4'(idx[k]);
      wt(1);
      checks++;
      if (rd_data !== want[k]) begin
        errors++;
        $display("FAIL config shadow[%0d] got %h want %h", idx[k], rd_data, want[k]);
      end
    end
    check_file("config");
  endtask

  task automatic test_bad_addr();
    logic [7:0] bad [2];
    logic [3:0] acks;
    int w0, l0, b0;
    bad = '{8'h36, 8'h35};
    for (int k = 0; k < 2; k++) begin
      w0 = we_cnt;
      l0 = dut_low;
      b0 = busy_hits;
      frame(bad[k], 8'h04, 8'h55, 8'h00, 3, acks);
      checks++;
      if (dut_low != l0 || we_cnt != w0 || busy_hits != b0 || acks != 4'd0) begin
        errors++;
        $display("FAIL bad_addr %h low=%0d we=%0d busy=%0d acks=%b want 0/0/0/0000",
                 bad[k], dut_low - l0, we_cnt - w0, busy_hits - b0, acks);
      end
    end
    frame(8'h34, 8'h0B, 8'h3C, 8'h00, 3, acks);
    mdl_write(8'h0B, 8'h3C);
    checks++;
    if (acks[2:0] !== 3'b111) begin
      errors++;
      $display("FAIL bad_addr recover acks got %b want 111", acks[2:0]);
    end
    check_last("bad_addr recover");
  endtask

  task automatic test_abort();
    logic a0, a1, a2;
    logic [3:0] acks;
    int w0;
    w0 = we_cnt;
    start_c();
    byte_out(8'h34, a0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort busy_after_match got %b want 1", busy);
    end
    byte_out(8'h04, a1);
    stop_c();
    checks++;
    if (we_cnt != w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort stop_after_byte1 we=%0d busy=%b want 0/0", we_cnt - w0, busy);
    end
    start_c();
    byte_out(8'h34, a0);
    byte_out(8'h08, a1);
    for (int i = 7; i >= 4; i--) bit_out(a1 ^ a1 ^ (8'hD6 >> i) & 1'b1, a2);
    start_c();
    byte_out(8'h34, a0);
    byte_out(8'h06, a1);
    byte_out(8'hD6, a2);
    stop_c();
    mdl_write(8'h06, 8'hD6);
    acks = {1'b0, a2, a1, a0};
    checks++;
    if (we_cnt - w0 !== 1 || acks !== 4'b0111) begin
      errors++;
      $display("FAIL abort rstart we=%0d acks=%b want 1/0111", we_cnt - w0, acks);
    end
    checks++;
    if (reg_addr !== 7'h03 || reg_data !== 9'h0D6) begin
      errors++;
      $display("FAIL abort rstart a/d got %h/%h want 03/0d6", reg_addr, reg_data);
    end
    check_last("abort");
  endtask

  task automatic test_reset_reg();
    logic [3:0] acks;
    int w0, l0;
    w0 = we_cnt;
    frame(8'h34, 8'h1E, 8'h00, 8'hA5, 4, acks);
    mdl_write(8'h1E, 8'h00);
    checks++;
    if (acks !== 4'b0111 || we_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL reset_reg acks=%b we=%0d want 0111/1", acks, we_cnt - w0);
    end
    check_last("reset_reg");
    check_file("reset_reg");
    l0 = dut_low;
    frame(8'h34, 8'h05, 8'h44, 8'h77, 4, acks);
    mdl_write(8'h05, 8'h44);
    checks++;
    if (acks[3] !== 1'b0 || dut_low - l0 < 1) begin
      errors++;
      $display("FAIL fourth_byte ack4=%b low=%0d want 0/>0", acks[3], dut_low - l0);
    end
    check_last("fourth_byte");
  endtask

  task automatic test_rst_ack1();
    logic a;
    logic [3:0] acks;
    start_c();
    byte_out(8'h34, a);
    bits_out(8'h04);
    wt(4);
    m_low = 1'b0;
    wt(3);
    checks++;
    if (sda !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack1 drive got sda=%b want 0", sda);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1 || busy !== 1'b0 || reg_we !== 1'b0 ||
        reg_addr !== 7'd0 || reg_data !== 9'd0 || xfer_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_ack1 outputs sda=%b busy=%b we=%b a=%h d=%h c=%h want 1/0/0/0/0/0",
               sda, busy, reg_we, reg_addr, reg_data, xfer_cnt);
    end
    mdl_reset();
    wt(2);
    rst_n = 1'b1;
    scl = 1'b1;
    wt(5);
    scl = 1'b0;
    stop_c();
    check_file("rst_ack1");
    frame(8'h34, 8'h03, 8'h99, 8'h00, 3, acks);
    mdl_write(8'h03, 8'h99);
    checks++;
    if (acks[2:0] !== 3'b111) begin
      errors++;
      $display("FAIL rst_ack1 next acks got %b want 111", acks[2:0]);
    end
    check_last("rst_ack1 next");
  endtask

  task automatic test_random();
    logic [3:0] acks, want;
    logic [7:0] ab, b1, b2;
    int kind, w0, wn;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b1 = 8'h1E;
        b2 = 8'h00;
      end
      ab = 8'h34;
      if (kind == 2) begin
        ab = 8'($urandom);
        if (ab == 8'h34) ab = 8'h36;
      end
      w0 = we_cnt;
      frame(ab, b1, b2, 8'($urandom), (kind == 3) ? 4 : 3, acks);
      if (kind == 2) begin
        want = 4'b0000;
        wn = 0;
      end else begin
        want = 4'b0111;
        wn = 1;
        mdl_write(b1, b2);
      end
      checks++;
      if (acks !== want || we_cnt - w0 !== wn) begin
        errors++;
        $display("FAIL random it%0d acks=%b we=%0d want %b/%0d", it, acks, we_cnt - w0, want, wn);
      end
      check_last("random");
    end
    check_file("random");
    checks++;
    if (we_double != 0) begin
      errors++;
      $display("FAIL we_width long pulses got %0d want 0", we_double);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_config();
    test_bad_addr();
    test_abort();
    test_reset_reg();
    test_rst_ack1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
